// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port with a pending-write scoreboard.
// Optional REGFILE_WB_FWD_EN adds write-stage forwarding ports and drops that term from hazards.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*5-1:0] req_rdi,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic              wr_en,
  output logic [4:0]        wr_rdi,
  output logic [XLEN-1:0]   wr_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rdi,
  input  logic [4:0]        chk_rsi1,
  input  logic [4:0]        chk_rsi2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [31:0]       pending
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data
`endif
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_found;
  logic            hs;
  logic [4:0]      sel_rdi;
  logic [XLEN-1:0] sel_data;
  logic            wr_en_q;
  logic [4:0]      wr_rdi_q;
  logic [XLEN-1:0] wr_data_q;
  logic [31:0]     pend_q, pend_d;
  logic            wb_hit1, wb_hit2;

  // Round-robin: first valid index above the pointer, else wrap to the lowest valid one.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (ARB_MODE == 1) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = IdxW'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] && (IdxW'(i) > ptr_q)) begin
          gnt_found = 1'b1;
          gnt_idx   = IdxW'(i);
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] && (IdxW'(i) <= ptr_q)) begin
          gnt_found = 1'b1;
          gnt_idx   = IdxW'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_rdi   = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt_found && !rst && (gnt_idx == IdxW'(i));
      if (gnt_idx == IdxW'(i)) begin
        sel_rdi  = req_rdi[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
    hs = |(req_valid & req_ready);
  end

  // Set is applied after clear so a newer producer of the same register stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (hs) begin
      pend_d[sel_rdi] = 1'b0;
    end
    if (iss_valid) begin
      pend_d[iss_rdi] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_rdi_q  <= '0;
      wr_data_q <= '0;
      ptr_q     <= IdxW'(NREQ - 1);
      pend_q    <= '0;
    end else begin
      wr_en_q <= hs && (sel_rdi != 5'd0);
      if (hs) begin
        wr_rdi_q  <= sel_rdi;
        wr_data_q <= sel_data;
        ptr_q     <= gnt_idx;
      end
      pend_q <= pend_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_rdi  = wr_rdi_q;
  assign wr_data = wr_data_q;
  assign pending = pend_q;

  // A read in the write cycle still sees the old register value.
  assign wb_hit1 = wr_en_q && (wr_rdi_q == chk_rsi1) && (chk_rsi1 != 5'd0);
  assign wb_hit2 = wr_en_q && (wr_rdi_q == chk_rsi2) && (chk_rsi2 != 5'd0);

`ifdef REGFILE_WB_FWD_EN
  assign hazard1   = pend_q[chk_rsi1];
  assign hazard2   = pend_q[chk_rsi2];
  assign fwd1_hit  = wb_hit1;
  assign fwd2_hit  = wb_hit2;
  assign fwd1_data = wr_data_q;
  assign fwd2_data = wr_data_q;
`else
  assign hazard1 = pend_q[chk_rsi1] | wb_hit1;
  assign hazard2 = pend_q[chk_rsi2] | wb_hit2;
`endif

endmodule
